// File: rtl/duc_pkg.sv
// duc_pkg: shared I/Q lane types and the saturating gain helper used by DUC and DDC
// Contents: IQ_W lane width, iq_lane_t {data, last}, sat_shift() -> {saturated, result}
package duc_pkg;

    localparam int IQ_W = 16;

    typedef struct packed {
        logic signed [IQ_W-1:0] data;
        logic                   last;
    } iq_lane_t;

    // Eight guard bits cover shifts 0..7. The result saturates when the guard bits
    // and the result sign bit are not all copies of the true sign.
    function automatic logic [IQ_W:0] sat_shift(input logic signed [IQ_W-1:0] x, input int sh);
        logic signed [IQ_W+7:0] w;
        logic                   hi;
        logic                   lo;
        w  = {{8{x[IQ_W-1]}}, x} <<< sh;
        hi = !w[IQ_W+7] && (|w[IQ_W+6:IQ_W-1]);
        lo = w[IQ_W+7] && !(&w[IQ_W+6:IQ_W-1]);
        return {hi | lo, hi ? {1'b0, {(IQ_W-1){1'b1}}} : lo ? {1'b1, {(IQ_W-1){1'b0}}} : w[IQ_W-1:0]};
    endfunction

endpackage

// File: rtl/duc_lane_fifo.sv
// duc_lane_fifo: per-lane synchronous FIFO of iq_lane_t with registered ready
// Ports: aclk/aresetn clock and async active-low reset; push_valid/push_ready/push_data write side;
//        pop/pop_data/empty read side (first-word fall-through)
module duc_lane_fifo
    import duc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     aclk,
    input  logic     aresetn,
    input  logic     push_valid,
    output logic     push_ready,
    input  iq_lane_t push_data,
    input  logic     pop,
    output iq_lane_t pop_data,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    iq_lane_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          push;
    logic          pop_en;

    // Ready is registered from the next occupancy, so a pop frees space only
    // on the following cycle and there is no pop-to-ready combinational path.
    always_comb begin
        push     = push_valid && ready_q;
        pop_en   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop_en);
        ready_d  = count_d != (AW+1)'(DEPTH);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign push_ready = ready_q;
    assign pop_data   = mem[rd_ptr_q];
    assign empty      = count_q == '0;

endmodule

// File: rtl/duc_iq_merge.sv
// duc_iq_merge: realigns I/Q AXI-Stream lanes, applies saturating gain, emits {Q,I}
// Ports: aclk/aresetn clock and async active-low reset; s_axis_i_*/s_axis_q_* 16-bit lane inputs;
//        m_axis_* merged 32-bit output; clr_flags clears last_mismatch/sat_seen;
//        frame_cnt/sample_cnt output frame and beat counters
module duc_iq_merge
    import duc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SHIFT      = 0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_i_tvalid,
    output logic              s_axis_i_tready,
    input  logic [IQ_W-1:0]   s_axis_i_tdata,
    input  logic              s_axis_i_tlast,
    input  logic              s_axis_q_tvalid,
    output logic              s_axis_q_tready,
    input  logic [IQ_W-1:0]   s_axis_q_tdata,
    input  logic              s_axis_q_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [2*IQ_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              clr_flags,
    output logic              last_mismatch,
    output logic              sat_seen,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       sample_cnt
);

    iq_lane_t          i_in, q_in, i_out, q_out;
    logic              empty_i, empty_q;
    logic              fire, hs;
    logic [IQ_W:0]     g_i, g_q;
    logic              m_valid_q, m_valid_d;
    logic [2*IQ_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              mism_q, mism_d;
    logic              sat_q, sat_d;
    logic [15:0]       frame_q, frame_d;
    logic [15:0]       sample_q, sample_d;

    assign i_in = {s_axis_i_tdata, s_axis_i_tlast};
    assign q_in = {s_axis_q_tdata, s_axis_q_tlast};

    duc_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_i (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push_valid (s_axis_i_tvalid),
        .push_ready (s_axis_i_tready),
        .push_data  (i_in),
        .pop        (fire),
        .pop_data   (i_out),
        .empty      (empty_i)
    );

    duc_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_q (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push_valid (s_axis_q_tvalid),
        .push_ready (s_axis_q_tready),
        .push_data  (q_in),
        .pop        (fire),
        .pop_data   (q_out),
        .empty      (empty_q)
    );

    // Flag set terms are OR'ed after the clear so a same-cycle event wins.
    always_comb begin
        fire      = !empty_i && !empty_q && (!m_valid_q || m_axis_tready);
        hs        = m_valid_q && m_axis_tready;
        g_i       = sat_shift(i_out.data, SHIFT);
        g_q       = sat_shift(q_out.data, SHIFT);
        m_valid_d = fire || (m_valid_q && !m_axis_tready);
        m_data_d  = fire ? {g_q[IQ_W-1:0], g_i[IQ_W-1:0]} : m_data_q;
        m_last_d  = fire ? (i_out.last | q_out.last) : m_last_q;
        sat_d     = (fire && (g_i[IQ_W] || g_q[IQ_W])) || (sat_q && !clr_flags);
        mism_d    = (fire && (i_out.last != q_out.last)) || (mism_q && !clr_flags);
        frame_d   = frame_q + 16'(hs && m_last_q);
        sample_d  = !hs ? sample_q : m_last_q ? 16'd0 : sample_q + 16'd1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            sat_q     <= 1'b0;
            mism_q    <= 1'b0;
            frame_q   <= '0;
            sample_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            sat_q     <= sat_d;
            mism_q    <= mism_d;
            frame_q   <= frame_d;
            sample_q  <= sample_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign sat_seen      = sat_q;
    assign last_mismatch = mism_q;
    assign frame_cnt     = frame_q;
    assign sample_cnt    = sample_q;

endmodule
